// File: rtl/set_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : set_access_controller
// Purpose  : Request sequencer for one set of an N-way cache. Accepts a CPU
//            load/store, performs a one-cycle tag lookup against the per-way
//            state presented on the way_* inputs, and then either completes
//            the access as a hit or runs the miss sequence: optional dirty
//            writeback, block refill request, wait for refill data, and
//            allocation of the chosen victim way.
// Ports    :
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       CPU request handshake (ready only in IDLE)
//   req_write/addr/wdata      CPU request fields, latched on acceptance
//   resp_valid/hit/rdata      one-cycle response strobe with hit flag, data
//   way_tag/valid/dirty/
//   way_expired/age/data      per-way state from the way storage, way i at
//                             slice i of each packed bus
//   way_wEn/way_allocate      one-hot write / allocate pulses to the ways
//   way_dataIn/way_address    shared write data and allocation address
//   accessed/accessedWayAge   access pulse and age of the touched way
//   mem_req_*/mem_addr/wdata  block-level memory request (writeback/refill)
//   mem_resp_valid/mem_rdata  refill data return
// Revision : 1.0 - initial release
// ============================================================================
module set_access_controller #(
  parameter  int NUM_WAYS      = 4,
  parameter  int DATA_WIDTH    = 32,
  parameter  int BLOCK_SIZE    = 32,
  parameter  int ADDRESS_WIDTH = 32,
  parameter  int COUNTER_WIDTH = 8,
  localparam int OFFSET_WIDTH  = $clog2(BLOCK_SIZE),
  localparam int TAG_WIDTH     = ADDRESS_WIDTH - OFFSET_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  // CPU request / response
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_write,
  input  logic [ADDRESS_WIDTH-1:0]          req_addr,
  input  logic [DATA_WIDTH-1:0]             req_wdata,
  output logic                              resp_valid,
  output logic                              resp_hit,
  output logic [DATA_WIDTH-1:0]             resp_rdata,
  // Way storage interface
  input  logic [NUM_WAYS*TAG_WIDTH-1:0]     way_tag,
  input  logic [NUM_WAYS-1:0]               way_valid,
  input  logic [NUM_WAYS-1:0]               way_dirty,
  input  logic [NUM_WAYS-1:0]               way_expired,
  input  logic [NUM_WAYS*COUNTER_WIDTH-1:0] way_age,
  input  logic [NUM_WAYS*DATA_WIDTH-1:0]    way_data,
  output logic [NUM_WAYS-1:0]               way_wEn,
  output logic [NUM_WAYS-1:0]               way_allocate,
  output logic [DATA_WIDTH-1:0]             way_dataIn,
  output logic [ADDRESS_WIDTH-1:0]          way_address,
  output logic                              accessed,
  output logic [COUNTER_WIDTH-1:0]          accessedWayAge,
  // Memory interface
  output logic                              mem_req_valid,
  input  logic                              mem_req_ready,
  output logic                              mem_req_write,
  output logic [ADDRESS_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  input  logic                              mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]             mem_rdata
);

  localparam int c_WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOOKUP      = 3'd1,
    S_WRITEBACK   = 3'd2,
    S_REFILL_REQ  = 3'd3,
    S_REFILL_WAIT = 3'd4,
    S_RESPOND     = 3'd5
  } state_t;

  state_t                     r_state;

  // Latched request
  logic                       r_reqWrite;
  logic [ADDRESS_WIDTH-1:0]   r_reqAddr;
  logic [DATA_WIDTH-1:0]      r_reqWdata;

  // Miss bookkeeping: victim index plus a snapshot of its block address and
  // data, so the writeback request stays stable while memory stalls.
  logic [c_WAY_W-1:0]         r_victim;
  logic [ADDRESS_WIDTH-1:0]   r_wbAddr;
  logic [DATA_WIDTH-1:0]      r_wbData;

  // Response registers
  logic                       r_respHit;
  logic [DATA_WIDTH-1:0]      r_respRdata;

  // Per-way views of the packed input buses
  logic [TAG_WIDTH-1:0]       w_tag  [NUM_WAYS];
  logic [COUNTER_WIDTH-1:0]   w_age  [NUM_WAYS];
  logic [DATA_WIDTH-1:0]      w_data [NUM_WAYS];

  logic [TAG_WIDTH-1:0]       w_reqTag;
  logic                       w_hit;
  logic [c_WAY_W-1:0]         w_hitWay;
  logic                       w_hasInvalid;
  logic [c_WAY_W-1:0]         w_invalidWay;
  logic                       w_hasExpired;
  logic [c_WAY_W-1:0]         w_expiredWay;
  logic [c_WAY_W-1:0]         w_victim;
  logic [DATA_WIDTH-1:0]      w_fillData;
  logic                       w_victimDirty;

  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_unpack
    assign w_tag[gi]  = way_tag [gi*TAG_WIDTH     +: TAG_WIDTH];
    assign w_age[gi]  = way_age [gi*COUNTER_WIDTH +: COUNTER_WIDTH];
    assign w_data[gi] = way_data[gi*DATA_WIDTH    +: DATA_WIDTH];
  end

  function automatic logic [NUM_WAYS-1:0] f_oneHot(input logic [c_WAY_W-1:0] idx);
    f_oneHot      = '0;
    f_oneHot[idx] = 1'b1;
  endfunction

  assign w_reqTag   = r_reqAddr[ADDRESS_WIDTH-1:OFFSET_WIDTH];
  // A store miss writes the CPU word, a load miss writes the returned word.
  assign w_fillData = r_reqWrite ? r_reqWdata : mem_rdata;

  // Hit detection and victim choice. Loops walk from the top index down so
  // the last assignment, i.e. the lowest matching index, wins.
  always_comb begin
    w_hit        = 1'b0;
    w_hitWay     = '0;
    w_hasInvalid = 1'b0;
    w_invalidWay = '0;
    w_hasExpired = 1'b0;
    w_expiredWay = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (way_valid[i] && (w_tag[i] == w_reqTag)) begin
        w_hit    = 1'b1;
        w_hitWay = c_WAY_W'(i);
      end
      if (!way_valid[i]) begin
        w_hasInvalid = 1'b1;
        w_invalidWay = c_WAY_W'(i);
      end
      if (way_expired[i]) begin
        w_hasExpired = 1'b1;
        w_expiredWay = c_WAY_W'(i);
      end
    end
    // Prefer a free way, then the LRU-flagged way, else fall back to way 0.
    if (w_hasInvalid) begin
      w_victim = w_invalidWay;
    end else if (w_hasExpired) begin
      w_victim = w_expiredWay;
    end else begin
      w_victim = '0;
    end
  end

  assign w_victimDirty = way_valid[w_victim] && way_dirty[w_victim];

  // Control and handshake outputs. The way-write pulses are suppressed while
  // rst is high so a reset landing on a lookup or refill cycle never
  // corrupts the set.
  always_comb begin
    req_ready      = (r_state == S_IDLE) && !rst;
    resp_valid     = 1'b0;
    way_wEn        = '0;
    way_allocate   = '0;
    way_dataIn     = '0;
    way_address    = '0;
    accessed       = 1'b0;
    accessedWayAge = '0;
    mem_req_valid  = 1'b0;
    mem_req_write  = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    case (r_state)
      S_LOOKUP: begin
        if (w_hit && !rst) begin
          accessed       = 1'b1;
          accessedWayAge = w_age[w_hitWay];
          if (r_reqWrite) begin
            way_wEn    = f_oneHot(w_hitWay);
            way_dataIn = r_reqWdata;
          end
        end
      end
      S_WRITEBACK: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_addr      = r_wbAddr;
        mem_wdata     = r_wbData;
      end
      S_REFILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_addr      = {w_reqTag, {OFFSET_WIDTH{1'b0}}};
      end
      S_REFILL_WAIT: begin
        if (mem_resp_valid && !rst) begin
          way_allocate   = f_oneHot(r_victim);
          way_wEn        = f_oneHot(r_victim);
          way_address    = r_reqAddr;
          way_dataIn     = w_fillData;
          accessed       = 1'b1;
          accessedWayAge = w_age[r_victim];
        end
      end
      S_RESPOND: begin
        resp_valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign resp_hit   = r_respHit;
  assign resp_rdata = r_respRdata;

  // Sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_reqWrite  <= 1'b0;
      r_reqAddr   <= '0;
      r_reqWdata  <= '0;
      r_victim    <= '0;
      r_wbAddr    <= '0;
      r_wbData    <= '0;
      r_respHit   <= 1'b0;
      r_respRdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_reqWrite <= req_write;
            r_reqAddr  <= req_addr;
            r_reqWdata <= req_wdata;
            r_state    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_respHit   <= 1'b1;
            r_respRdata <= r_reqWrite ? r_reqWdata : w_data[w_hitWay];
            r_state     <= S_RESPOND;
          end else begin
            r_respHit <= 1'b0;
            r_victim  <= w_victim;
            r_wbAddr  <= {w_tag[w_victim], {OFFSET_WIDTH{1'b0}}};
            r_wbData  <= w_data[w_victim];
            r_state   <= w_victimDirty ? S_WRITEBACK : S_REFILL_REQ;
          end
        end
        S_WRITEBACK: begin
          if (mem_req_ready) begin
            r_state <= S_REFILL_REQ;
          end
        end
        S_REFILL_REQ: begin
          // Returned data can only belong to this refill once the request
          // has been accepted, so mem_resp_valid is not looked at here.
          if (mem_req_ready) begin
            r_state <= S_REFILL_WAIT;
          end
        end
        S_REFILL_WAIT: begin
          if (mem_resp_valid) begin
            r_respRdata <= w_fillData;
            r_state     <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_set_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_set_access_controller
// Purpose  : Self-checking bench for set_access_controller. A transaction
//            model derives hit/victim/writeback decisions and a cycle
//            timeline from the set contents and memory stall settings, and
//            every cycle of every transaction is compared to it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_set_access_controller;

  localparam int NW = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int OW = 5;
  localparam int TW = AW - OW;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              req_valid, req_ready, req_write;
  logic [AW-1:0]     req_addr;
  logic [DW-1:0]     req_wdata;
  logic              resp_valid, resp_hit;
  logic [DW-1:0]     resp_rdata;
  logic [NW*TW-1:0]  way_tag;
  logic [NW-1:0]     way_valid, way_dirty, way_expired;
  logic [NW*CW-1:0]  way_age;
  logic [NW*DW-1:0]  way_data;
  logic [NW-1:0]     way_wEn, way_allocate;
  logic [DW-1:0]     way_dataIn;
  logic [AW-1:0]     way_address;
  logic              accessed;
  logic [CW-1:0]     accessedWayAge;
  logic              mem_req_valid, mem_req_ready, mem_req_write;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_resp_valid;
  logic [DW-1:0]     mem_rdata;

  // Set contents as seen by the model
  logic [TW-1:0] mTag [NW];
  logic          mVld [NW];
  logic          mDrt [NW];
  logic          mExp [NW];
  logic [CW-1:0] mAge [NW];
  logic [DW-1:0] mDat [NW];

  for (genvar g = 0; g < NW; g++) begin : g_pack
    assign way_tag[g*TW +: TW]  = mTag[g];
    assign way_valid[g]         = mVld[g];
    assign way_dirty[g]         = mDrt[g];
    assign way_expired[g]       = mExp[g];
    assign way_age[g*CW +: CW]  = mAge[g];
    assign way_data[g*DW +: DW] = mDat[g];
  end

  int vectors = 0;
  int errors  = 0;

  set_access_controller dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
    .way_tag(way_tag), .way_valid(way_valid), .way_dirty(way_dirty),
    .way_expired(way_expired), .way_age(way_age), .way_data(way_data),
    .way_wEn(way_wEn), .way_allocate(way_allocate), .way_dataIn(way_dataIn),
    .way_address(way_address), .accessed(accessed), .accessedWayAge(accessedWayAge),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  task automatic clear_ways();
    for (int i = 0; i < NW; i++) begin
      mTag[i] = TW'($urandom); mVld[i] = 1'b0; mDrt[i] = 1'b0;
      mExp[i] = 1'b0; mAge[i] = CW'($urandom); mDat[i] = $urandom;
    end
  endtask

  // Runs one complete transaction from an idle controller. s1/s2 are the
  // writeback/refill-request stall cycles, lat the refill data latency.
  // Entered and left just after a falling edge.
  task automatic run_txn(input string nm, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] mdata,
                         input int s1, input int s2, input int lat, input bit holdValid);
    bit            hit, wb, inWb, inRq, inWt;
    int            hitWay, victim, rqStart, rqEnd, wtEnd, respK, lastK;
    logic [TW-1:0] tag;
    logic [DW-1:0] fill, respData, eAge8, eDin;
    logic [NW-1:0] eWen, eAlloc;
    bit            eAcc, eReady, eResp, eMemV, eMemW;
    logic [AW-1:0] eMemA;

    // Reference decisions from the set contents
    tag = addr[AW-1:OW];
    hit = 1'b0; hitWay = 0;
    for (int i = 0; i < NW; i++)
      if (!hit && mVld[i] && mTag[i] == tag) begin hit = 1'b1; hitWay = i; end
    victim = -1;
    for (int i = 0; i < NW; i++) if (victim < 0 && !mVld[i]) victim = i;
    for (int i = 0; i < NW; i++) if (victim < 0 && mExp[i]) victim = i;
    if (victim < 0) victim = 0;
    wb       = !hit && mVld[victim] && mDrt[victim];
    fill     = wr ? wdata : mdata;
    respData = hit ? (wr ? wdata : mDat[hitWay]) : fill;
    // Timeline: cycle 1 is lookup, then writeback, refill request, wait
    rqStart = 0; rqEnd = 0; wtEnd = 0;
    if (hit) begin
      respK = 2;
    end else begin
      rqStart = wb ? 3 + s1 : 2;
      rqEnd   = rqStart + s2;
      wtEnd   = rqEnd + 1 + lat;
      respK   = wtEnd + 1;
    end
    lastK = respK + 1;

    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL %s accept req_ready got %b exp 1", nm, req_ready); end

    for (int k = 1; k <= lastK; k++) begin
      @(posedge clk); #1;
      req_valid = holdValid && (k < lastK);
      if (k == 1) begin
        req_addr = $urandom; req_wdata = $urandom; req_write = 1'($urandom_range(0, 1));
      end
      inWb = wb && k >= 2 && k <= 2 + s1;
      inRq = !hit && k >= rqStart && k <= rqEnd;
      inWt = !hit && k > rqEnd && k <= wtEnd;
      mem_req_ready  = inWb ? (k == 2 + s1) : inRq ? (k == rqEnd) : 1'($urandom_range(0, 1));
      mem_resp_valid = inWt ? (k == wtEnd) : 1'($urandom_range(0, 1));
      mem_rdata      = (inWt && k == wtEnd) ? mdata : $urandom;
      @(negedge clk);

      eReady = (k == lastK);
      eResp  = (k == respK);
      eMemV  = inWb || inRq;
      eMemW  = inWb;
      eMemA  = inWb ? {mTag[victim], {OW{1'b0}}} : {tag, {OW{1'b0}}};
      eWen = '0; eAlloc = '0; eAcc = 1'b0; eAge8 = '0; eDin = '0;
      if (hit && k == 1) begin
        eAcc = 1'b1; eAge8 = DW'(mAge[hitWay]);
        if (wr) begin eWen = NW'(1) << hitWay; eDin = wdata; end
      end
      if (!hit && k == wtEnd) begin
        eAlloc = NW'(1) << victim; eWen = eAlloc; eAcc = 1'b1;
        eAge8 = DW'(mAge[victim]); eDin = fill;
      end

      vectors += 6;
      if (req_ready !== eReady) begin errors++; $display("FAIL %s k=%0d req_ready got %b exp %b", nm, k, req_ready, eReady); end
      if (resp_valid !== eResp) begin errors++; $display("FAIL %s k=%0d resp_valid got %b exp %b", nm, k, resp_valid, eResp); end
      if (mem_req_valid !== eMemV) begin errors++; $display("FAIL %s k=%0d mem_req_valid got %b exp %b", nm, k, mem_req_valid, eMemV); end
      if (way_wEn !== eWen) begin errors++; $display("FAIL %s k=%0d way_wEn got %b exp %b", nm, k, way_wEn, eWen); end
      if (way_allocate !== eAlloc) begin errors++; $display("FAIL %s k=%0d way_allocate got %b exp %b", nm, k, way_allocate, eAlloc); end
      if (accessed !== eAcc) begin errors++; $display("FAIL %s k=%0d accessed got %b exp %b", nm, k, accessed, eAcc); end
      if (eMemV) begin
        vectors += 2;
        if (mem_req_write !== eMemW) begin errors++; $display("FAIL %s k=%0d mem_req_write got %b exp %b", nm, k, mem_req_write, eMemW); end
        if (mem_addr !== eMemA) begin errors++; $display("FAIL %s k=%0d mem_addr got %h exp %h", nm, k, mem_addr, eMemA); end
      end
      if (eMemW) begin
        vectors++;
        if (mem_wdata !== mDat[victim]) begin errors++; $display("FAIL %s k=%0d mem_wdata got %h exp %h", nm, k, mem_wdata, mDat[victim]); end
      end
      if (eAcc) begin
        vectors++;
        if (accessedWayAge !== eAge8[CW-1:0]) begin errors++; $display("FAIL %s k=%0d accessedWayAge got %h exp %h", nm, k, accessedWayAge, eAge8[CW-1:0]); end
      end
      if (eWen != '0) begin
        vectors++;
        if (way_dataIn !== eDin) begin errors++; $display("FAIL %s k=%0d way_dataIn got %h exp %h", nm, k, way_dataIn, eDin); end
      end
      if (eAlloc != '0) begin
        vectors++;
        if (way_address !== addr) begin errors++; $display("FAIL %s k=%0d way_address got %h exp %h", nm, k, way_address, addr); end
      end
      if (eResp) begin
        vectors += 2;
        if (resp_hit !== hit) begin errors++; $display("FAIL %s k=%0d resp_hit got %b exp %b", nm, k, resp_hit, hit); end
        if (resp_rdata !== respData) begin errors++; $display("FAIL %s k=%0d resp_rdata got %h exp %h", nm, k, resp_rdata, respData); end
      end
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
  endtask

  task automatic random_txn(input string nm, input bit hold);
    logic [TW-1:0] pool [4];
    logic [TW-1:0] tag;
    for (int j = 0; j < 4; j++) pool[j] = TW'($urandom);
    for (int i = 0; i < NW; i++) begin
      mTag[i] = pool[$urandom_range(0, 3)];
      mVld[i] = ($urandom_range(0, 3) != 0);
      mDrt[i] = 1'($urandom_range(0, 1));
      mExp[i] = ($urandom_range(0, 2) == 0);
      mAge[i] = CW'($urandom);
      mDat[i] = $urandom;
    end
    tag = ($urandom_range(0, 9) < 7) ? pool[$urandom_range(0, 3)] : TW'($urandom);
    run_txn(nm, 1'($urandom_range(0, 1)), {tag, OW'($urandom)}, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), hold);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = $urandom; req_wdata = $urandom;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = $urandom;
    clear_ways();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    @(negedge clk);
    vectors += 8;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready got %b exp 1", req_ready); end
    if ({resp_valid, resp_hit, accessed, mem_req_valid, mem_req_write} !== 5'b0) begin
      errors++; $display("FAIL reset strobes got %b exp 00000", {resp_valid, resp_hit, accessed, mem_req_valid, mem_req_write});
    end
    if (resp_rdata !== '0) begin errors++; $display("FAIL reset resp_rdata got %h exp 0", resp_rdata); end
    if ({way_wEn, way_allocate} !== '0) begin errors++; $display("FAIL reset way pulses got %b exp 0", {way_wEn, way_allocate}); end
    if (way_dataIn !== '0) begin errors++; $display("FAIL reset way_dataIn got %h exp 0", way_dataIn); end
    if (way_address !== '0 || accessedWayAge !== '0) begin errors++; $display("FAIL reset way_address/age got %h/%h exp 0/0", way_address, accessedWayAge); end
    if (mem_addr !== '0) begin errors++; $display("FAIL reset mem_addr got %h exp 0", mem_addr); end
    if (mem_wdata !== '0) begin errors++; $display("FAIL reset mem_wdata got %h exp 0", mem_wdata); end
  endtask

  task automatic test_cold_miss();
    clear_ways();
    run_txn("cold_miss", 1'b0, 32'h0000_1040, $urandom, 32'hDEAD_BEEF, 0, 0, 1, 1'b0);
  endtask

  task automatic test_hit();
    clear_ways();
    for (int i = 0; i < NW; i++) begin mVld[i] = 1'b1; mTag[i] = TW'(32'h300 + i); end
    mTag[2] = TW'(32'h0000_1040 >> OW);
    run_txn("hit_way2_load", 1'b0, 32'h0000_1040, $urandom, $urandom, 0, 0, 0, 1'b0);
    run_txn("hit_way2_store", 1'b1, 32'h0000_1044, 32'hCAFE_0001, $urandom, 0, 0, 0, 1'b0);
    mTag[3] = mTag[2]; mTag[1] = mTag[2];
    run_txn("multi_hit_lowest", 1'b0, 32'h0000_105C, $urandom, $urandom, 0, 0, 0, 1'b0);
  endtask

  task automatic test_dirty_writeback();
    clear_ways();
    for (int i = 0; i < NW; i++) begin mVld[i] = 1'b1; mDrt[i] = 1'b1; mTag[i] = TW'(32'h500 + i); end
    mExp[1] = 1'b1;
    run_txn("dirty_wb_way1", 1'b0, 32'h0007_7000, $urandom, 32'h0BAD_F00D, 0, 0, 2, 1'b0);
  endtask

  task automatic test_store_miss();
    clear_ways();
    for (int i = 0; i < NW; i++) mVld[i] = 1'b1;
    mExp[3] = 1'b1;
    run_txn("store_miss", 1'b1, 32'h0001_2340, 32'h2222_2222, 32'h1111_1111, 0, 1, 1, 1'b0);
  endtask

  task automatic test_wb_stall();
    clear_ways();
    for (int i = 0; i < NW; i++) begin mVld[i] = 1'b1; mTag[i] = TW'(32'h700 + i); end
    mDrt[0] = 1'b1;
    run_txn("wb_stall5", 1'b0, 32'h00AB_CD00, $urandom, $urandom, 5, 2, 0, 1'b0);
  endtask

  // Reset while stalled in writeback (sc 0) or while refill data arrives (sc 1)
  task automatic test_reset_mid_txn();
    for (int sc = 0; sc < 2; sc++) begin
      clear_ways();
      if (sc == 0) begin
        for (int i = 0; i < NW; i++) begin mVld[i] = 1'b1; mTag[i] = TW'(32'h900 + i); end
        mDrt[0] = 1'b1;
      end
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0004_4440; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      mem_req_ready = (sc == 1);
      @(negedge clk);
      vectors += 2;
      if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rst_mid%0d mem_req_valid got %b exp 1", sc, mem_req_valid); end
      if (mem_req_write !== (sc == 0)) begin errors++; $display("FAIL rst_mid%0d mem_req_write got %b exp %b", sc, mem_req_write, sc == 0); end
      @(posedge clk); #1;
      rst = 1'b1; mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = $urandom;
      @(negedge clk);
      vectors += 2;
      if (way_allocate !== '0 || way_wEn !== '0) begin errors++; $display("FAIL rst_mid%0d way write got %b/%b exp 0/0", sc, way_allocate, way_wEn); end
      if (accessed !== 1'b0) begin errors++; $display("FAIL rst_mid%0d accessed got %b exp 0", sc, accessed); end
      @(posedge clk); #1;
      rst = 1'b0; mem_resp_valid = 1'b0;
      @(negedge clk);
      vectors += 3;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid%0d req_ready got %b exp 1", sc, req_ready); end
      if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mid%0d mem_req_valid after got %b exp 0", sc, mem_req_valid); end
      if (way_allocate !== '0 || resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid%0d alloc/resp after got %b/%b exp 0/0", sc, way_allocate, resp_valid); end
      @(posedge clk); #1;
      @(negedge clk);
      vectors++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid%0d idle got resp %b ready %b exp 0 1", sc, resp_valid, req_ready); end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 8; n++) random_txn("back_to_back", 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) random_txn("random", 1'b0);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_dirty_writeback();
    test_store_miss();
    test_wb_stall();
    test_reset_mid_txn();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
